// File: rtl/mor1kx_bpred_pkg.sv
// ----------------------------------------------------------------------------
// mor1kx_bpred_pkg
//
// Shared types and helpers for the gshare branch predictor.
//   bpred_state_t : predictor FSM state (table sweep vs. active)
//   fold_hist()   : XOR-folds the global history onto the table index width
//   sat_inc()     : saturating up-count of a pattern counter
//   sat_dec()     : saturating down-count of a pattern counter
//   weak_taken()  : weakly-taken counter value for a given counter width
//
// The helpers operate on fixed maximum widths (64-bit history, 32-bit index,
// 4-bit counter) so one function serves every parameterisation; callers
// widen their operands and take the low bits of the result.
// ----------------------------------------------------------------------------
package mor1kx_bpred_pkg;

    typedef enum logic {
        FSM_INIT  = 1'b0,
        FSM_READY = 1'b1
    } bpred_state_t;

    localparam int MAX_HIST_BITS  = 64;
    localparam int MAX_INDEX_BITS = 32;
    localparam int MAX_CNT_BITS   = 4;

    // History bit b lands on index bit (b mod index_bits). This is the same
    // as XORing index_bits-wide chunks together with the top chunk
    // zero-extended, and degenerates to plain zero-extension when the
    // history is shorter than the index.
    function automatic logic [MAX_INDEX_BITS-1:0] fold_hist(
        input logic [MAX_HIST_BITS-1:0] hist,
        input int                       hist_bits,
        input int                       index_bits
    );
        logic [MAX_INDEX_BITS-1:0] folded;
        int                        pos;
        folded = '0;
        for (int b = 0; b < MAX_HIST_BITS; b++) begin
            if (b < hist_bits) begin
                pos = b % index_bits;
                folded[pos[4:0]] = folded[pos[4:0]] ^ hist[b];
            end
        end
        return folded;
    endfunction

    function automatic logic [MAX_CNT_BITS-1:0] sat_inc(
        input logic [MAX_CNT_BITS-1:0] cnt,
        input int                      cnt_bits
    );
        logic [MAX_CNT_BITS-1:0] max_val;
        max_val = MAX_CNT_BITS'((1 << cnt_bits) - 1);
        return (cnt >= max_val) ? max_val : cnt + 1'b1;
    endfunction

    function automatic logic [MAX_CNT_BITS-1:0] sat_dec(
        input logic [MAX_CNT_BITS-1:0] cnt
    );
        return (cnt == '0) ? '0 : cnt - 1'b1;
    endfunction

    function automatic logic [MAX_CNT_BITS-1:0] weak_taken(
        input int cnt_bits
    );
        return MAX_CNT_BITS'(1 << (cnt_bits - 1));
    endfunction

endpackage

// File: rtl/mor1kx_bpred_pht.sv
// ----------------------------------------------------------------------------
// mor1kx_bpred_pht
//
// Pattern history table: 2^INDEX_BITS saturating counters of CNT_BITS each.
// One asynchronous read port (prediction lookup) and one synchronous write
// port (init sweep or resolve update). The array has no reset; the owner
// fills it with a known value after reset before using it.
//
// Ports
//   clk      in   1           clock
//   rd_idx   in   INDEX_BITS  read index
//   rd_data  out  CNT_BITS    counter at rd_idx, combinational
//   wr_en    in   1           write strobe
//   wr_idx   in   INDEX_BITS  write index
//   wr_data  in   CNT_BITS    value written at the next rising edge
// ----------------------------------------------------------------------------
module mor1kx_bpred_pht
    import mor1kx_bpred_pkg::*;
#(
    parameter int INDEX_BITS = 10,
    parameter int CNT_BITS   = 2
) (
    input  logic                  clk,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic [CNT_BITS-1:0]   rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [CNT_BITS-1:0]   wr_data
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [CNT_BITS-1:0] mem [0:ENTRIES-1];

    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/mor1kx_branch_predictor_gshare_ckpt.sv
// ----------------------------------------------------------------------------
// mor1kx_branch_predictor_gshare_ckpt
//
// gshare predictor for l.bf / l.bnf in decode. The global history is updated
// speculatively with each prediction and restored from a checkpoint taken at
// prediction time when the branch turns out to be mispredicted. After reset
// the pattern table is swept to weakly-taken, one entry per cycle, before
// the predictor becomes active.
//
// Ports
//   clk               in   1    clock
//   rst               in   1    asynchronous active-high reset
//   predict_req_i     in   1    conditional branch accepted in decode
//   predict_bf_i      in   1    1 = l.bf, 0 = l.bnf
//   predict_pc_i      in   OPW  branch PC
//   predicted_flag_o  out  1    predicted SR[F], combinational
//   ready_o           out  1    table sweep finished, predictor active
//   resolve_valid_i   in   1    pending branch resolved in execute
//   resolve_flag_i    in   1    actual SR[F]
//   mispredict_o      out  1    registered 1-cycle mispredict pulse
//   stat_clear_i      in   1    synchronous clear of the statistics
//   stat_pred_o       out  32   accepted predictions, saturating
//   stat_mispred_o    out  32   mispredicts, saturating
// ----------------------------------------------------------------------------
module mor1kx_branch_predictor_gshare_ckpt
    import mor1kx_bpred_pkg::*;
#(
    parameter int INDEX_BITS           = 10,
    parameter int HIST_BITS            = 12,
    parameter int CNT_BITS             = 2,
    parameter int OPTION_OPERAND_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            predict_req_i,
    input  logic                            predict_bf_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] predict_pc_i,
    output logic                            predicted_flag_o,
    output logic                            ready_o,
    input  logic                            resolve_valid_i,
    input  logic                            resolve_flag_i,
    output logic                            mispredict_o,
    input  logic                            stat_clear_i,
    output logic [31:0]                     stat_pred_o,
    output logic [31:0]                     stat_mispred_o
);

    bpred_state_t state;
    bpred_state_t state_next;

    logic [INDEX_BITS-1:0] sweep_idx;
    logic                  sweep_last;
    logic                  ready;

    logic [HIST_BITS-1:0]  ghr;
    logic [HIST_BITS-1:0]  ckpt;

    logic                  pending;
    logic [INDEX_BITS-1:0] pend_idx;
    logic                  pend_bf;
    logic                  pend_taken;
    logic [CNT_BITS-1:0]   pend_cnt;

    logic [MAX_INDEX_BITS-1:0] folded_hist;
    logic [INDEX_BITS-1:0]     pred_idx;
    logic [CNT_BITS-1:0]       pht_rd_data;
    logic                      taken_pred;

    logic                      do_resolve;
    logic                      actual_taken;
    logic                      mispred;
    logic                      accept;
    logic [MAX_CNT_BITS-1:0]   inc_wide;
    logic [MAX_CNT_BITS-1:0]   dec_wide;
    logic [MAX_CNT_BITS-1:0]   weak_wide;
    logic [CNT_BITS-1:0]       upd_cnt;

    logic                      pht_wr_en;
    logic [INDEX_BITS-1:0]     pht_wr_idx;
    logic [CNT_BITS-1:0]       pht_wr_data;

    logic [31:0]               stat_pred_q;
    logic [31:0]               stat_mispred_q;

    logic                      unused_bits;

    assign sweep_last = (sweep_idx == {INDEX_BITS{1'b1}});
    assign ready      = (state == FSM_READY);
    assign ready_o    = ready;

    // FSM state register. The sweep always restarts from INIT on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FSM_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Leave INIT on the cycle that writes the final table entry.
    always_comb begin
        state_next = state;
        case (state)
            FSM_INIT:  if (sweep_last) state_next = FSM_READY;
            FSM_READY: state_next = FSM_READY;
            default:   state_next = FSM_INIT;
        endcase
    end

    // Sweep pointer walks every table entry once while in INIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_idx <= '0;
        end else if (state == FSM_INIT) begin
            sweep_idx <= sweep_idx + 1'b1;
        end
    end

    // Prediction lookup: folded history XOR word-aligned PC bits.
    assign folded_hist = fold_hist(MAX_HIST_BITS'(ghr), HIST_BITS, INDEX_BITS);
    assign pred_idx    = folded_hist[INDEX_BITS-1:0] ^ predict_pc_i[INDEX_BITS+1:2];
    assign taken_pred  = pht_rd_data[CNT_BITS-1];

    // l.bnf branches when the flag is clear, so its predicted flag is the
    // inverse of the taken prediction. Nothing is predicted during INIT.
    assign predicted_flag_o = ready & (predict_bf_i ? taken_pred : ~taken_pred);

    // A mispredicting resolve flushes a request arriving in the same cycle,
    // since that request was fetched down the wrong path.
    assign do_resolve   = ready & resolve_valid_i & pending;
    assign actual_taken = pend_bf ? resolve_flag_i : ~resolve_flag_i;
    assign mispred      = do_resolve & (actual_taken != pend_taken);
    assign accept       = ready & predict_req_i & ~mispred;

    // The counter value was captured at prediction time, so the update needs
    // no second read port on the table.
    assign inc_wide  = sat_inc(MAX_CNT_BITS'(pend_cnt), CNT_BITS);
    assign dec_wide  = sat_dec(MAX_CNT_BITS'(pend_cnt));
    assign weak_wide = weak_taken(CNT_BITS);
    assign upd_cnt   = actual_taken ? inc_wide[CNT_BITS-1:0] : dec_wide[CNT_BITS-1:0];

    // Table write port: sweep during INIT, resolve update afterwards.
    always_comb begin
        pht_wr_en   = 1'b0;
        pht_wr_idx  = pend_idx;
        pht_wr_data = upd_cnt;
        if (state == FSM_INIT) begin
            pht_wr_en   = 1'b1;
            pht_wr_idx  = sweep_idx;
            pht_wr_data = weak_wide[CNT_BITS-1:0];
        end else if (do_resolve) begin
            pht_wr_en = 1'b1;
        end
    end

    mor1kx_bpred_pht #(
        .INDEX_BITS (INDEX_BITS),
        .CNT_BITS   (CNT_BITS)
    ) u_pht (
        .clk     (clk),
        .rd_idx  (pred_idx),
        .rd_data (pht_rd_data),
        .wr_en   (pht_wr_en),
        .wr_idx  (pht_wr_idx),
        .wr_data (pht_wr_data)
    );

    // History, checkpoint and pending-branch bookkeeping. When a correct
    // resolve updates the very entry a new branch just read, the captured
    // counter takes the updated value so the next update starts from it; the
    // prediction itself still uses the pre-update value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr          <= '0;
            ckpt         <= '0;
            pending      <= 1'b0;
            pend_idx     <= '0;
            pend_bf      <= 1'b0;
            pend_taken   <= 1'b0;
            pend_cnt     <= '0;
            mispredict_o <= 1'b0;
        end else begin
            mispredict_o <= mispred;
            if (mispred) begin
                ghr     <= {ckpt[HIST_BITS-2:0], actual_taken};
                pending <= 1'b0;
            end else if (accept) begin
                ghr        <= {ghr[HIST_BITS-2:0], taken_pred};
                ckpt       <= ghr;
                pending    <= 1'b1;
                pend_idx   <= pred_idx;
                pend_bf    <= predict_bf_i;
                pend_taken <= taken_pred;
                pend_cnt   <= (do_resolve && (pred_idx == pend_idx)) ? upd_cnt : pht_rd_data;
            end else if (do_resolve) begin
                pending <= 1'b0;
            end
        end
    end

    // Saturating statistics; clear has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pred_q    <= '0;
            stat_mispred_q <= '0;
        end else if (stat_clear_i) begin
            stat_pred_q    <= '0;
            stat_mispred_q <= '0;
        end else begin
            if (accept && (stat_pred_q != 32'hFFFF_FFFF)) begin
                stat_pred_q <= stat_pred_q + 32'd1;
            end
            if (mispred && (stat_mispred_q != 32'hFFFF_FFFF)) begin
                stat_mispred_q <= stat_mispred_q + 32'd1;
            end
        end
    end

    assign stat_pred_o    = stat_pred_q;
    assign stat_mispred_o = stat_mispred_q;

    assign unused_bits = ^{folded_hist, inc_wide, dec_wide, weak_wide, predict_pc_i};

`ifndef SYNTHESIS
    // Decode must not hand over a new branch while one is still unresolved.
    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        !(ready && predict_req_i && pending && !resolve_valid_i));
`endif

endmodule

// File: tb/tb_mor1kx_branch_predictor_gshare_ckpt.sv
// ----------------------------------------------------------------------------
// tb_mor1kx_branch_predictor_gshare_ckpt
//
// Directed bench for the gshare predictor with default parameters
// (INDEX_BITS=10, HIST_BITS=12, CNT_BITS=2). Expected history values are
// worked out by hand from the sequence of predictions and resolves.
// ----------------------------------------------------------------------------
module tb_mor1kx_branch_predictor_gshare_ckpt;

    logic        clk;
    logic        rst;
    logic        predict_req;
    logic        predict_bf;
    logic [31:0] predict_pc;
    logic        predicted_flag;
    logic        ready;
    logic        resolve_valid;
    logic        resolve_flag;
    logic        mispredict;
    logic        stat_clear;
    logic [31:0] stat_pred;
    logic [31:0] stat_mispred;

    int vectors;
    int miscompares;
    logic last_flag;

    mor1kx_branch_predictor_gshare_ckpt dut (
        .clk              (clk),
        .rst              (rst),
        .predict_req_i    (predict_req),
        .predict_bf_i     (predict_bf),
        .predict_pc_i     (predict_pc),
        .predicted_flag_o (predicted_flag),
        .ready_o          (ready),
        .resolve_valid_i  (resolve_valid),
        .resolve_flag_i   (resolve_flag),
        .mispredict_o     (mispredict),
        .stat_clear_i     (stat_clear),
        .stat_pred_o      (stat_pred),
        .stat_mispred_o   (stat_mispred)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, capture the combinational prediction before
    // the edge, then return all inputs to idle just after the edge.
    task automatic applyStimulus(input logic req, input logic bf, input logic [31:0] pc,
                                 input logic rv, input logic rf, input logic clr);
        predict_req   = req;
        predict_bf    = bf;
        predict_pc    = pc;
        resolve_valid = rv;
        resolve_flag  = rf;
        stat_clear    = clr;
        #1;
        last_flag = predicted_flag;
        @(posedge clk);
        #1;
        predict_req   = 1'b0;
        predict_bf    = 1'b0;
        predict_pc    = '0;
        resolve_valid = 1'b0;
        resolve_flag  = 1'b0;
        stat_clear    = 1'b0;
    endtask

    // Pulse reset and count edges until ready rises, bounded.
    task automatic resetAndWait(output int cycles);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles = 0;
        while (!ready && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!ready) begin
            checkOutput("ready_timeout", 64'(ready), 64'd1);
        end
    endtask

    initial begin
        int cyc;
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        predict_req   = 1'b0;
        predict_bf    = 1'b0;
        predict_pc    = '0;
        resolve_valid = 1'b0;
        resolve_flag  = 1'b0;
        stat_clear    = 1'b0;
        last_flag     = 1'b0;

        // Reset state.
        @(posedge clk);
        #1;
        checkOutput("rst_ready",        64'(ready),        64'd0);
        checkOutput("rst_mispredict",   64'(mispredict),   64'd0);
        checkOutput("rst_stat_pred",    64'(stat_pred),    64'd0);
        checkOutput("rst_stat_mispred", 64'(stat_mispred), 64'd0);

        // Run 300 cycles of INIT with a branch request held; nothing is
        // predicted, then reset mid-sweep and time the restarted sweep.
        rst = 1'b0;
        predict_req = 1'b1;
        predict_bf  = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("init_flag",  64'(predicted_flag), 64'd0);
        checkOutput("init_ready", 64'(ready),          64'd0);
        predict_req = 1'b0;
        predict_bf  = 1'b0;
        resetAndWait(cyc);
        checkOutput("init_cycles",     64'(cyc),       64'd1024);
        checkOutput("init_stat_pred",  64'(stat_pred), 64'd0);

        // l.bf at 0x100, always resolved with flag=1.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
            checkOutput("bf_pred_flag", 64'(last_flag), 64'd1);
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        checkOutput("bf4_flag",         64'(last_flag),    64'd1);
        checkOutput("bf4_stat_pred",    64'(stat_pred),    64'd4);
        checkOutput("bf4_stat_mispred", 64'(stat_mispred), 64'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("bf4_mispredict",   64'(mispredict),   64'd0);
        checkOutput("bf4_ghr",          64'(dut.ghr),      64'hF);

        // l.bf at PC 0 (idx 0x0F) resolved not-taken: first mispredict,
        // history restored to 0xF<<1|0 and entry 0x0F drops to 01.
        applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("mp1_pulse", 64'(mispredict),   64'd1);
        checkOutput("mp1_ghr",   64'(dut.ghr),      64'h1E);
        checkOutput("mp1_stat",  64'(stat_mispred), 64'd1);

        // l.bnf at 0x44 hits entry 0x1E^0x11=0x0F: predicted not-taken, so
        // the predicted flag is 1. Flag=0 resolves it taken: mispredict.
        applyStimulus(1'b1, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0);
        checkOutput("bnf_flag",       64'(last_flag),  64'd1);
        checkOutput("bnf_pulse_low",  64'(mispredict), 64'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("bnf_pulse",      64'(mispredict),   64'd1);
        checkOutput("bnf_ghr",        64'(dut.ghr),      64'h3D);
        checkOutput("bnf_stat",       64'(stat_mispred), 64'd2);
        checkOutput("bnf_stat_pred",  64'(stat_pred),    64'd6);

        // Mispredicting resolve with a new request in the same cycle.
        applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_pre_stat", 64'(stat_pred), 64'd7);
        applyStimulus(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_pulse",     64'(mispredict),   64'd1);
        checkOutput("flush_pending",   64'(dut.pending),  64'd0);
        checkOutput("flush_stat_pred", 64'(stat_pred),    64'd7);
        checkOutput("flush_ghr",       64'(dut.ghr),      64'h7A);
        checkOutput("flush_stat_mp",   64'(stat_mispred), 64'd3);

        // Correct resolve with a new request in the same cycle.
        applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("both_flag",      64'(last_flag),   64'd1);
        checkOutput("both_pending",   64'(dut.pending), 64'd1);
        checkOutput("both_stat_pred", 64'(stat_pred),   64'd9);
        checkOutput("both_ghr",       64'(dut.ghr),     64'h1EB);
        checkOutput("both_no_pulse",  64'(mispredict),  64'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("both_drain",     64'(dut.pending), 64'd0);

        // Resolve with nothing pending is ignored.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("idle_res_pulse", 64'(mispredict),   64'd0);
        checkOutput("idle_res_stat",  64'(stat_mispred), 64'd3);
        checkOutput("idle_res_ghr",   64'(dut.ghr),      64'h1EB);

        // Mispredict counter saturation, then clear beating an increment.
        @(negedge clk);
        force dut.stat_mispred_q = 32'hFFFF_FFFF;
        #1;
        release dut.stat_mispred_q;
        applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("sat_pulse", 64'(mispredict),   64'd1);
        checkOutput("sat_stat",  64'(stat_mispred), 64'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("clr_pulse",     64'(mispredict),   64'd1);
        checkOutput("clr_stat_mp",   64'(stat_mispred), 64'd0);
        checkOutput("clr_stat_pred", 64'(stat_pred),    64'd0);

        // Fresh table, 12 correct taken predictions at PC 0 fill the history
        // with ones; index at PC 0 is then 0x3FF ^ 0x003 = 0x3FC.
        resetAndWait(cyc);
        checkOutput("reinit_cycles", 64'(cyc), 64'd1024);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("fold_ghr",       64'(dut.ghr),      64'hFFF);
        checkOutput("fold_stat_pred", 64'(stat_pred),    64'd12);
        checkOutput("fold_stat_mp",   64'(stat_mispred), 64'd0);
        predict_pc = 32'h0;
        predict_bf = 1'b0;
        #1;
        checkOutput("fold_idx",      64'(dut.pred_idx),  64'h3FC);
        checkOutput("fold_bnf_flag", 64'(predicted_flag), 64'd0);
        predict_bf = 1'b1;
        #1;
        checkOutput("fold_bf_flag",  64'(predicted_flag), 64'd1);
        predict_bf = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
